// File: rtl/line_window_gen.sv
// Sliding KxK window generator for a binary raster stream.
// A (K-1)-line shift chain feeds registered window taps. An IDLE/RUN/DONE FSM handles frame start, abort and completion.
module line_window_gen #(
    parameter int MAX_W = 28,
    parameter int MAX_H = 28,
    parameter int K     = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     img_w,
    input  logic [7:0]     img_h,
    input  logic           din_valid,
    input  logic           din,
    output logic [K*K-1:0] win,
    output logic           win_valid,
    output logic           busy,
    output logic           frame_done,
    output logic           cfg_err
);

    localparam int CHAIN_LEN = (K - 1) * MAX_W + K;
    localparam int OFF_W     = $clog2(CHAIN_LEN);
    localparam int CW        = $clog2(MAX_W);
    localparam int RW        = $clog2(MAX_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [7:0]           w_lat_q;
    logic [7:0]           h_lat_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [K*K-1:0]       win_q;
    logic                 win_valid_q;
    logic                 frame_done_q;
    logic                 cfg_err_q;

    // The register holds the older CHAIN_LEN-1 pixels.
    // Together with din it forms the full chain as seen after the shift.
    logic [CHAIN_LEN-2:0] chain_q;
    logic [CHAIN_LEN-1:0] chain_d;
    logic [K*K-1:0]       win_d;
    logic [OFF_W-1:0]     off;
    logic                 cfg_ok;
    logic                 start_ok;
    logic                 accept;
    logic                 col_last;
    logic                 row_last;
    logic                 win_pos;

    // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        cfg_ok   = (img_w >= 8'(K)) && (img_w <= 8'(MAX_W)) &&
                   (img_h >= 8'(K)) && (img_h <= 8'(MAX_H));
        start_ok = start && cfg_ok;
        accept   = (state_q == S_RUN) && din_valid && !start_ok;
        col_last = (col_q == CW'(w_lat_q - 8'd1));
        row_last = (row_q == RW'(h_lat_q - 8'd1));
        win_pos  = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
        chain_d  = {chain_q, din};
        win_d    = '0;
        off      = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                off            = OFF_W'(K - 1 - r) * OFF_W'(w_lat_q) + OFF_W'(K - 1 - c);
                win_d[r*K + c] = chain_d[off];
            end
        end
    end

    // NOTE: the line store has no reset; every tap is overwritten by pixels of the current frame before it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            chain_q <= chain_d[CHAIN_LEN-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            w_lat_q      <= '0;
            h_lat_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= start && !cfg_ok;
            if (state_q == S_DONE) begin
                state_q <= S_IDLE;
            end

            if (start_ok) begin
                state_q <= S_RUN;
                w_lat_q <= img_w;
                h_lat_q <= img_h;
                col_q   <= '0;
                row_q   <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                if (win_pos) begin
                    win_valid_q <= 1'b1;
                    win_q       <= win_d;
                end
                if (row_last && col_last) begin
                    frame_done_q <= 1'b1;
                    state_q      <= S_DONE;
                end
            end
        end
    end

    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_line_window_gen.sv
// Self-checking bench for line_window_gen.
// Expected windows are cut directly out of a 2-D image array.
module tb_line_window_gen;

    localparam int MAX_W = 28;
    localparam int MAX_H = 28;
    localparam int K     = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [7:0]     img_w;
    logic [7:0]     img_h;
    logic           din_valid;
    logic           din;
    logic [K*K-1:0] win;
    logic           win_valid;
    logic           busy;
    logic           frame_done;
    logic           cfg_err;

    always #5 clk = ~clk;

    line_window_gen #(.MAX_W(MAX_W), .MAX_H(MAX_H), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_w      (img_w),
        .img_h      (img_h),
        .din_valid  (din_valid),
        .din        (din),
        .win        (win),
        .win_valid  (win_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit             img [MAX_H][MAX_W];
    logic [K*K-1:0] obs_q[$];
    logic [K*K-1:0] exp_q[$];
    logic [K*K-1:0] ref_q[$];
    int             n_valid, n_done, n_done_alone, n_cfg, n_busy, n_acc, first_at;
    int             cur_w, cur_h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, take the edge, sample outputs 1 time unit later.
    task automatic tick(input bit s, input int w, input int h, input bit dv, input bit d, input bit r);
        rst       = r;
        start     = s;
        img_w     = 8'(w);
        img_h     = 8'(h);
        din_valid = dv;
        din       = d;
        @(posedge clk);
        #1;
        if (win_valid === 1'b1) begin
            obs_q.push_back(win);
            n_valid++;
            if (first_at < 0) first_at = n_acc;
        end
        if (frame_done === 1'b1) begin
            n_done++;
            if (win_valid !== 1'b1) n_done_alone++;
        end
        if (cfg_err === 1'b1) n_cfg++;
        if (busy === 1'b1) n_busy++;
    endtask

    task automatic clear_stats();
        obs_q.delete();
        n_valid = 0; n_done = 0; n_done_alone = 0; n_cfg = 0; n_busy = 0;
        n_acc = 0; first_at = -1;
    endtask

    task automatic fill_img(input int mode);
        for (int r = 0; r < MAX_H; r++)
            for (int c = 0; c < MAX_W; c++)
                img[r][c] = (mode == 1) ? (((r * 7 + c) % 3) == 0) : bit'($urandom_range(0, 1));
    endtask

    // Every window that is complete within the first n raster pixels of a w-wide frame.
    task automatic build_exp(input int w, input int n);
        logic [K*K-1:0] v;
        exp_q.delete();
        for (int idx = 0; idx < n; idx++) begin
            int r, c;
            r = idx / w;
            c = idx % w;
            if (r >= K - 1 && c >= K - 1) begin
                for (int wr = 0; wr < K; wr++)
                    for (int wc = 0; wc < K; wc++)
                        v[wr*K + wc] = img[r-K+1+wr][c-K+1+wc];
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic compare_obs(input string tag);
        int errs0, n;
        errs0 = n_errors;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_win%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
            if (n_errors - errs0 > 5) break;
        end
    endtask

    task automatic start_frame(input int w, input int h);
        cur_w = w;
        cur_h = h;
        tick(1'b1, w, h, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixels(input int from, input int to, input int bubble_pct);
        for (int idx = from; idx < to; idx++) begin
            for (int b = 0; b < 20 && $urandom_range(0, 99) < bubble_pct; b++)
                tick(1'b0, cur_w, cur_h, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
            n_acc++;
            tick(1'b0, cur_w, cur_h, 1'b1, img[idx / cur_w][idx % cur_w], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, cur_w, cur_h, 1'b1, bit'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        cur_w = MAX_W;
        cur_h = MAX_H;
        clear_stats();

        // Reset overrides start and din_valid.
        tick(1'b1, 28, 28, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 28, 28, 1'b1, 1'b1, 1'b1);
        chk("rst_win", 32'(win), 32'(0));
        chk("rst_win_valid", 32'(win_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_cfg_err", 32'(cfg_err), 32'(0));

        // 28x28 frame without bubbles.
        clear_stats();
        fill_img(0);
        start_frame(28, 28);
        chk("full_busy_after_start", 32'(busy), 32'(1));
        send_pixels(0, 784, 0);
        chk("full_first_valid_pixel", 32'(first_at), 32'(59));
        chk("full_pulses", 32'(n_valid), 32'(676));
        chk("full_frame_done", 32'(n_done), 32'(1));
        chk("full_done_alone", 32'(n_done_alone), 32'(0));
        idle(2);
        chk("full_busy_after_done", 32'(busy), 32'(0));
        chk("full_no_extra_done", 32'(n_done), 32'(1));
        build_exp(28, 784);
        compare_obs("full");
        ref_q = obs_q;

        // Same frame with about 40% bubbles: identical window sequence.
        clear_stats();
        start_frame(28, 28);
        send_pixels(0, 784, 40);
        idle(2);
        chk("bubble_pulses", 32'(n_valid), 32'(676));
        chk("bubble_frame_done", 32'(n_done), 32'(1));
        chk("bubble_done_alone", 32'(n_done_alone), 32'(0));
        exp_q = ref_q;
        compare_obs("bubble_vs_clean");

        // 26x26 patterned frame; a bad start mid-frame is rejected without disturbing it.
        clear_stats();
        fill_img(1);
        start_frame(26, 26);
        send_pixels(0, 200, 10);
        tick(1'b1, 26, 0, 1'b0, 1'b0, 1'b0);
        chk("pat_badstart_cfg_err", 32'(cfg_err), 32'(1));
        chk("pat_badstart_busy", 32'(busy), 32'(1));
        send_pixels(200, 676, 10);
        idle(2);
        chk("pat_pulses", 32'(n_valid), 32'(576));
        chk("pat_cfg_err_count", 32'(n_cfg), 32'(1));
        chk("pat_frame_done", 32'(n_done), 32'(1));
        build_exp(26, 676);
        compare_obs("pat");

        // Out-of-range widths are rejected; pixels are ignored outside RUN.
        clear_stats();
        tick(1'b1, 2, 28, 1'b0, 1'b0, 1'b0);
        chk("cfg_w2_err", 32'(cfg_err), 32'(1));
        idle(10);
        tick(1'b1, 29, 28, 1'b0, 1'b0, 1'b0);
        chk("cfg_w29_err", 32'(cfg_err), 32'(1));
        idle(10);
        chk("cfg_err_count", 32'(n_cfg), 32'(2));
        chk("cfg_busy", 32'(n_busy), 32'(0));
        chk("cfg_no_valid", 32'(n_valid), 32'(0));

        // Reset mid-frame discards it; the next frame is complete and correct.
        clear_stats();
        fill_img(0);
        start_frame(28, 28);
        send_pixels(0, 300, 0);
        tick(1'b1, 28, 28, 1'b1, 1'b1, 1'b1);
        chk("midrst_win", 32'(win), 32'(0));
        chk("midrst_win_valid", 32'(win_valid), 32'(0));
        clear_stats();
        idle(5);
        chk("midrst_quiet_valid", 32'(n_valid), 32'(0));
        chk("midrst_quiet_done", 32'(n_done), 32'(0));
        chk("midrst_quiet_busy", 32'(n_busy), 32'(0));
        fill_img(0);
        start_frame(28, 28);
        send_pixels(0, 784, 0);
        idle(2);
        chk("midrst_frame_done", 32'(n_done), 32'(1));
        build_exp(28, 784);
        compare_obs("midrst");

        // Start reissued after pixel 100 aborts silently; the second frame is correct.
        clear_stats();
        fill_img(0);
        start_frame(28, 28);
        send_pixels(0, 100, 0);
        build_exp(28, 100);
        compare_obs("abort_partial");
        fill_img(0);
        obs_q.delete();
        start_frame(28, 28);
        chk("abort_no_done", 32'(n_done), 32'(0));
        send_pixels(0, 784, 20);
        idle(2);
        chk("abort_frame_done", 32'(n_done), 32'(1));
        build_exp(28, 784);
        compare_obs("abort_second");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 The module SHALL have parameter MAX_W, default 28, giving the maximum image width in pixels.
REQ-002 The module SHALL have parameter MAX_H, default 28, giving the maximum image height in rows.
REQ-003 The module SHALL have parameter K, default 3, giving the square window size; legal range 2..5.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: a one-cycle pulse that loads img_w/img_h and begins a frame.
REQ-007 The module SHALL have port img_w, input, 8 bits: frame width, sampled only on start.
REQ-008 The module SHALL have port img_h, input, 8 bits: frame height, sampled only on start.
REQ-009 The module SHALL have port din_valid, input, 1 bit: din carries a pixel this cycle.
REQ-010 The module SHALL have port din, input, 1 bit: binary pixel, raster order.
REQ-011 The module SHALL have port win, output, K*K bits: the KxK binary window.
REQ-012 The module SHALL have port win_valid, output, 1 bit: win is valid this cycle.
REQ-013 The module SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.
REQ-015 The module SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-017 IDLE->RUN: on start with K<=img_w<=MAX_W and K<=img_h<=MAX_H; the widths are latched and col/row are cleared to 0.
REQ-018 start with out-of-range img_w or img_h SHALL assert cfg_err the next cycle; the state stays IDLE or RUN, unchanged.
REQ-019 A valid start while in RUN SHALL abort the current frame, relatch the widths and clear col/row; no frame_done SHALL be emitted for the aborted frame.
REQ-020 A pixel is accepted only when din_valid=1 in RUN; din_valid outside RUN SHALL be ignored.
REQ-021 The line store SHALL be a shift chain of (K-1)*MAX_W+K bits that shifts only on an accepted pixel, with the newest pixel entering index 0; the chain is not cleared by start.
REQ-022 col SHALL increment per accepted pixel and wrap to 0 at img_w-1, at which point row increments.
REQ-023 Tap mapping: win[r*K+c] = chain[(K-1-r)*img_w_lat + (K-1-c)], taken after the shift that includes the accepted pixel; bit 0 is the top-left (oldest) pixel.
REQ-024 win and win_valid SHALL be registered: win_valid=1 exactly one cycle after accepting a pixel with row>=K-1 and col>=K-1, and 0 otherwise.
REQ-025 win SHALL hold its value while win_valid=0.
REQ-026 No window SHALL straddle a row boundary; each frame SHALL yield exactly (img_w-K+1)*(img_h-K+1) win_valid pulses.
REQ-027 Accepting pixel (img_h-1, img_w-1) SHALL move the FSM to DONE; frame_done SHALL pulse in the same cycle as the final win_valid; DONE->IDLE follows unconditionally after 1 cycle.
REQ-028 Bubbles (din_valid=0) SHALL freeze the chain, counters and state; the output sequence SHALL be identical with and without bubbles.
REQ-029 A start arriving in DONE SHALL be honoured as in IDLE.
REQ-030 Counters SHALL be $clog2(MAX_W) and $clog2(MAX_H) bits wide; the tap offset SHALL be computed with a width holding (K-1)*MAX_W+K-1 without overflow.

Reset
REQ-031 rst=1 SHALL force the state to IDLE, col=row=0, and win=0, win_valid=0, busy=0, frame_done=0, cfg_err=0 at the next edge; the chain contents are don't-care.
REQ-032 rst SHALL override start and din_valid in the same cycle; reset mid-frame SHALL discard the frame with no further win_valid or frame_done.

Verification
REQ-033 Scenario: K=3, start with img_w=28 and img_h=28, 784 pixels without bubbles -> first win_valid one cycle after the 59th accepted pixel; 676 pulses; frame_done coincides with the last pulse.
REQ-034 Scenario: img_w=26, img_h=26 -> 576 pulses; win checked against a software model with pixel value = (row*7+col)%3==0.
REQ-035 Scenario: the REQ-033 frame with a random 40% din_valid=0 -> win sequence identical to the no-bubble run.
REQ-036 Scenario: start with img_w=2 or img_w=29 -> cfg_err pulses once, busy stays 0, no win_valid.
REQ-037 Scenario: rst asserted after pixel 300, then a new start with 28x28 -> no output between rst and start; the new frame produces exactly 676 correct windows.
REQ-038 Scenario: start reissued in RUN after pixel 100 -> no frame_done for the first frame; the second frame is correct.
